// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   result_t  : one full-scan result {kind, code}
//   KEY_MAP   : key code table indexed by {row, col}
//   COL_RESET : column drive after reset (column 0 active)
package keypad_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_KEY   = 2'd1,
    KIND_MULTI = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] code;
  } result_t;

  localparam result_t RESULT_NONE = '{kind: KIND_NONE, code: 4'h0};

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Rows top to bottom: 1 2 3 A | 4 5 6 B | 7 8 9 C | E 0 F D
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Merge two partial scan results; two hits of any kind become MULTI.
  function automatic result_t combine(input result_t a, input result_t b);
    if (a.kind == KIND_NONE) return b;
    if (b.kind == KIND_NONE) return a;
    return '{kind: KIND_MULTI, code: 4'h0};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces full-scan results.
//   clk, rst_n     : clock, async active-low reset
//   strobe_i       : one-cycle strobe, raw_i holds a complete scan result
//   raw_i          : full-scan result (MULTI is folded into NONE)
//   stable_c_o     : stable result as it will be after this cycle
//   press_c_o      : stable goes NONE -> KEY this cycle
//   release_c_o    : stable goes KEY -> NONE this cycle
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    strobe_i,
  input  result_t raw_i,
  output result_t stable_c_o,
  output logic    press_c_o,
  output logic    release_c_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  result_t            cand_q, cand_d;
  result_t            stable_q, stable_d;
  result_t            raw_n;
  logic [CNT_W-1:0]   count_q, count_d;

  // Candidate/count update and stable acceptance
  always_comb begin
    cand_d      = cand_q;
    count_d     = count_q;
    stable_d    = stable_q;
    press_c_o   = 1'b0;
    release_c_o = 1'b0;
    // Ghosting guard: ambiguous multi-key scans look like no key at all
    raw_n       = (raw_i.kind == KIND_KEY) ? raw_i : RESULT_NONE;
    if (strobe_i) begin
      if (raw_n == cand_q) begin
        if (count_q != CNT_W'(DEBOUNCE_SCANS)) count_d = count_q + CNT_W'(1);
      end else begin
        cand_d  = raw_n;
        count_d = CNT_W'(1);
      end
      if (count_d == CNT_W'(DEBOUNCE_SCANS) && cand_d != stable_q) begin
        stable_d    = cand_d;
        press_c_o   = (stable_q.kind == KIND_NONE);
        release_c_o = (cand_d.kind == KIND_NONE);
      end
    end
  end

  assign stable_c_o = stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= RESULT_NONE;
      count_q  <= '0;
      stable_q <= RESULT_NONE;
    end else begin
      cand_q   <= cand_d;
      count_q  <= count_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit entry register.
//   clk, rst_n : clock, async active-low reset
//   row        : keypad rows, active-low, asynchronous
//   col        : active-low one-hot column drive
//   key_code   : code of last accepted key
//   key_valid  : one-cycle pulse per accepted press
//   key_down   : a single debounced key is held
//   value      : entry register, newest digit in [3:0]
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  result_t           acc_q, acc_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_down_q, key_down_d;
  logic [15:0]       value_q, value_d;

  logic              sample;
  logic              strobe;
  logic [3:0]        row_low;
  logic [2:0]        n_low;
  logic [1:0]        row_idx;
  result_t           col_res;
  result_t           scan_res;
  result_t           stable_next;
  logic              press, release_ev;

  assign sample  = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign strobe  = sample && (col_idx_q == 2'd3);
  assign row_low = ~row_s2_q;

  // Count low rows in the current column and remember which one
  always_comb begin
    n_low   = '0;
    row_idx = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_low[r]) begin
        n_low   = n_low + 3'd1;
        row_idx = 2'(r);
      end
    end
  end

  always_comb begin
    col_res = RESULT_NONE;
    if (n_low == 3'd1) col_res = '{kind: KIND_KEY, code: KEY_MAP[{row_idx, col_idx_q}]};
    else if (n_low > 3'd1) col_res = '{kind: KIND_MULTI, code: 4'h0};
  end

  assign scan_res = combine(acc_q, col_res);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe_i   (strobe),
    .raw_i      (scan_res),
    .stable_c_o (stable_next),
    .press_c_o  (press),
    .release_c_o(release_ev)
  );

  // Scan counters, per-scan accumulation and output updates
  always_comb begin
    slot_d      = slot_q + SLOT_W'(1);
    col_idx_d   = col_idx_q;
    acc_d       = acc_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    value_d     = value_q;
    if (sample) begin
      slot_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
      acc_d     = strobe ? RESULT_NONE : scan_res;
    end
    col_d = ~(4'b0001 << col_idx_d);
    if (press) begin
      key_valid_d = 1'b1;
      key_code_d  = stable_next.code;
      key_down_d  = 1'b1;
      value_d     = {value_q[11:0], stable_next.code};
    end else if (release_ev) begin
      key_down_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      slot_q      <= '0;
      col_idx_q   <= '0;
      col_q       <= COL_RESET;
      acc_q       <= RESULT_NONE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      value_q     <= '0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      value_q     <= value_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a keypad matrix model and a pulse scoreboard.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 3;
  localparam int unsigned SCAN     = 4 * SCAN_DIV;
  localparam int unsigned BOUND    = (DEB + 2) * SCAN + 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_down;
  logic [15:0] value;

  logic [15:0] pressed;     // index r*4+c
  logic [15:0] model_val;
  logic        prev_valid;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;

  typedef struct {
    int          k;
    logic [3:0]  code;
    logic [15:0] value;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[8];

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .value    (value)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every key_valid pops one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        pulses++;
        check("valid_not_back_to_back", 32'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got code %0h value %0h, expected no pulse", key_code, value);
        end else begin
          e = exp_q.pop_front();
          check("pulse_code", 32'(key_code), 32'(e.code));
          check("pulse_value", 32'(value), 32'(e.value));
          check("pulse_key_down", 32'(key_down), 1);
        end
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push_expect(input logic [3:0] code);
    exp_t x;
    model_val = {model_val[11:0], code};
    x.code  = code;
    x.value = model_val;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("pulse_arrived_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic wait_key_down(input logic v);
    int n = 0;
    while (key_down !== v && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("key_down_level", 32'(key_down), 32'(v));
  endtask

  task automatic expect_press(input int k, input logic [3:0] code);
    pressed[k] = 1'b1;
    push_expect(code);
    wait_drain();
  endtask

  task automatic release_key(input int k);
    int pr;
    pr = pulses;
    pressed[k] = 1'b0;
    wait_key_down(1'b0);
    check("no_pulse_on_release", 32'(pulses), 32'(pr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_val = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ec;
    tbl[0] = '{0,  4'h1, 16'h0001};
    tbl[1] = '{1,  4'h2, 16'h0012};
    tbl[2] = '{2,  4'h3, 16'h0123};
    tbl[3] = '{4,  4'h4, 16'h1234};
    tbl[4] = '{3,  4'hA, 16'h234A};
    tbl[5] = '{12, 4'hE, 16'h34AE};
    tbl[6] = '{13, 4'h0, 16'h4AE0};
    tbl[7] = '{15, 4'hD, 16'hAE0D};

    pressed    = '0;
    model_val  = '0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_col", 32'(col), 32'(4'b1110));
    check("reset_key_code", 32'(key_code), 0);
    check("reset_key_valid", 32'(key_valid), 0);
    check("reset_key_down", 32'(key_down), 0);
    check("reset_value", 32'(value), 0);

    // Column rotation over one full scan
    rst_n = 1'b1;
    for (int i = 0; i < int'(SCAN); i++) begin
      ec = ~(4'b0001 << (i / int'(SCAN_DIV)));
      check("col_drive", 32'(col), 32'(ec));
      @(negedge clk);
    end

    // Single key r1c1
    expect_press(5, 4'h5);
    check("hold_key_down", 32'(key_down), 1);
    check("hold_key_code", 32'(key_code), 32'(4'h5));
    check("hold_value", 32'(value), 32'(16'h0005));
    release_key(5);

    // Reset mid-debounce with a key held
    pressed[5] = 1'b1;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_col", 32'(col), 32'(4'b1110));
    check("async_reset_value", 32'(value), 0);
    check("async_reset_key_down", 32'(key_down), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_val = '0;
    exp_q.delete();
    p0 = pulses;
    repeat (2 * SCAN) @(negedge clk);
    check("no_pulse_before_debounce", 32'(pulses), 32'(p0));
    push_expect(4'h5);
    wait_drain();
    release_key(5);

    // Bounce on r0c0: alternate scans, then hold
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pressed[0] = (i % 2 == 0);
      repeat (SCAN) @(negedge clk);
    end
    pressed[0] = 1'b1;
    repeat (2 * SCAN) @(negedge clk);
    check("bounce_no_pulse", 32'(pulses), 32'(p0));
    push_expect(4'h1);
    wait_drain();
    release_key(0);

    // Digit entry table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      expect_press(tbl[i].k, tbl[i].code);
      check("table_value", 32'(value), 32'(tbl[i].value));
      release_key(tbl[i].k);
    end

    // Two keys together, then one released
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    repeat (6 * SCAN) @(negedge clk);
    check("multi_key_down", 32'(key_down), 0);
    check("multi_no_pulse", 32'(pulses), 32'(p0));
    pressed[0] = 1'b0;
    push_expect(4'h5);
    wait_drain();
    release_key(5);

    // Slide 7 -> 8 without release
    expect_press(8, 4'h7);
    p0 = pulses;
    pressed[8] = 1'b0;
    pressed[9] = 1'b1;
    repeat (6 * SCAN) @(negedge clk);
    check("slide_no_pulse", 32'(pulses), 32'(p0));
    check("slide_key_down", 32'(key_down), 1);
    check("slide_key_code", 32'(key_code), 32'(4'h7));
    release_key(9);
    expect_press(9, 4'h8);
    check("slide_value_tail", 32'(value[7:0]), 32'(8'h78));
    release_key(9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
